// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sharing of one req/fin handshake adder among Num
// requesters. Operands are registered at grant, the adder result is captured
// on a synchronized add_fin rising edge or after a fixed timeout, and the
// granted requester sees a one-hot fin until it releases its request.
module add_arbiter #(
  parameter int Width   = 32,
  parameter int Num     = 4,
  parameter int Timeout = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [Num-1:0]       req,
  input  logic [Num*Width-1:0] x_bus,
  input  logic [Num*Width-1:0] y_bus,
  output logic [Num-1:0]       fin,
  output logic [Width-1:0]     so,
  output logic                 couto,
  output logic                 tmo,
  output logic                 add_req,
  output logic [Width-1:0]     add_x,
  output logic [Width-1:0]     add_y,
  input  logic [Width-1:0]     add_so,
  input  logic                 add_couto,
  input  logic                 add_fin
);

  localparam int PtrW = (Num > 1) ? $clog2(Num) : 1;
  localparam int CntW = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [PtrW:0]   NumW    = (PtrW + 1)'(Num);
  localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_e;

  state_e            state_q;
  logic [PtrW-1:0]   ptr_q;
  logic [PtrW-1:0]   grant_q;
  logic [CntW-1:0]   cnt_q;
  logic [Num-1:0]    fin_q;
  logic [Width-1:0]  so_q;
  logic              couto_q;
  logic              tmo_q;
  logic              add_req_q;
  logic [Width-1:0]  add_x_q;
  logic [Width-1:0]  add_y_q;

  // add_fin synchronizer: two metastability stages plus the edge register.
  logic              fin_s1_q;
  logic              fin_s2_q;
  logic              fin_s3_q;
  logic              fin_edge;

  // Arbitration helpers.
  logic [Num-1:0]    req_rot;
  logic [PtrW-1:0]   off_d;
  logic [PtrW:0]     gsum;
  logic [PtrW:0]     psum;
  logic [PtrW-1:0]   grant_d;
  logic [PtrW-1:0]   ptr_d;
  logic [Width-1:0]  x_d;
  logic [Width-1:0]  y_d;

  // Bring the asynchronous adder done into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fin_s1_q <= 1'b0;
      fin_s2_q <= 1'b0;
      fin_s3_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so each stage takes the previous stage's old value;
      // blocking here would collapse the chain into a single flop.
      fin_s1_q <= add_fin;
      fin_s2_q <= fin_s1_q;
      fin_s3_q <= fin_s2_q;
    end
  end

  assign fin_edge = fin_s2_q & ~fin_s3_q;

  // Round-robin pick starting at ptr, next pointer, and granted operands.
  always_comb begin
    // NOTE: every variable gets a value before any condition, so no path
    // leaves one unassigned and no latch is inferred.
    req_rot = Num'({req, req} >> ptr_q);
    off_d   = '0;
    for (int i = Num - 1; i >= 0; i--) begin
      if (req_rot[i]) off_d = PtrW'(i);
    end
    gsum = {1'b0, ptr_q} + {1'b0, off_d};
    if (gsum >= NumW) gsum = gsum - NumW;
    grant_d = gsum[PtrW-1:0];
    psum = {1'b0, grant_d} + (PtrW + 1)'(1);
    if (psum >= NumW) psum = psum - NumW;
    ptr_d = psum[PtrW-1:0];
    x_d = '0;
    y_d = '0;
    for (int i = 0; i < Num; i++) begin
      if (grant_d == PtrW'(i)) begin
        x_d = x_bus[i*Width +: Width];
        y_d = y_bus[i*Width +: Width];
      end
    end
  end

  // Operation sequencer: grant, raise add_req, capture result, wait release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: reset clears the operand and result registers too, so a reset
      // mid-operation leaves no stale value visible on any output.
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      fin_q     <= '0;
      so_q      <= '0;
      couto_q   <= 1'b0;
      tmo_q     <= 1'b0;
      add_req_q <= 1'b0;
      add_x_q   <= '0;
      add_y_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            add_x_q <= x_d;
            add_y_q <= y_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          add_req_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + CntW'(1);
          if (fin_edge || (cnt_q == CntLast)) begin
            so_q      <= add_so;
            couto_q   <= add_couto;
            tmo_q     <= ~fin_edge;
            add_req_q <= 1'b0;
            fin_q     <= Num'(1) << grant_q;
            state_q   <= DONE;
          end
        end
        DONE: begin
          // fin_q is one-hot on the grantee, so this tests req[grant] low.
          if (~|(req & fin_q)) begin
            fin_q   <= '0;
            tmo_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fin     = fin_q;
  assign so      = so_q;
  assign couto   = couto_q;
  assign tmo     = tmo_q;
  assign add_req = add_req_q;
  assign add_x   = add_x_q;
  assign add_y   = add_y_q;

endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed and randomized operations against a transaction
// level model (round-robin pick, expected sum, capture cycle from the add_fin
// delay and the timeout).
module tb_add_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int PW = 2;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [W-1:0]     xs [N];
  logic [W-1:0]     ys [N];
  logic [N*W-1:0]   x_bus;
  logic [N*W-1:0]   y_bus;
  logic [N-1:0]     fin;
  logic [W-1:0]     so;
  logic             couto;
  logic             tmo;
  logic             add_req;
  logic [W-1:0]     add_x;
  logic [W-1:0]     add_y;
  logic [W-1:0]     add_so;
  logic             add_couto;
  logic             add_fin;

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [PW-1:0]    m_ptr = '0;
  logic [W:0]       exp_sum;

  always #5 clk = ~clk;

  assign x_bus = {xs[3], xs[2], xs[1], xs[0]};
  assign y_bus = {ys[3], ys[2], ys[1], ys[0]};

  // Behavioural adder: result follows the registered operands.
  assign {add_couto, add_so} = {1'b0, add_x} + {1'b0, add_y};

  add_arbiter #(.Width(W), .Num(N), .Timeout(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .x_bus     (x_bus),
    .y_bus     (y_bus),
    .fin       (fin),
    .so        (so),
    .couto     (couto),
    .tmo       (tmo),
    .add_req   (add_req),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_so    (add_so),
    .add_couto (add_couto),
    .add_fin   (add_fin)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Round-robin rule: first requesting index scanning p, p+1, ... mod N.
  function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) begin
      t = r >> ((int'(p) + i) % N);
      if (t[0]) return PW'((int'(p) + i) % N);
    end
    return p;
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One operation for grantee g. k = cycles after add_req rises at which
  // add_fin pulses (-1: never). drop/chg act one cycle into the wait.
  task automatic run_op(input logic [PW-1:0] g, input int k, input bit drop, input bit chg);
    logic [W-1:0] ex, ey;
    int           tcap;
    bit           by_fin;
    ex      = xs[g];
    ey      = ys[g];
    exp_sum = {1'b0, ex} + {1'b0, ey};
    by_fin  = (k >= 0) && (k + 3 <= TO);
    tcap    = by_fin ? k + 3 : TO;
    cycle();
    check("grant_x", 64'(add_x), 64'(ex));
    check("grant_y", 64'(add_y), 64'(ey));
    check("grant_idle", 64'({add_req, fin}), 64'(0));
    cycle();
    for (int t = 0; t < tcap; t++) begin
      check("wait", 64'({add_req, fin}), 64'({1'b1, N'(0)}));
      add_fin = (t == k);
      if (chg && t == 1) begin
        xs[g] = $urandom;
        ys[g] = $urandom;
      end
      if (drop && t == 1) req[g] = 1'b0;
      cycle();
    end
    add_fin = 1'b0;
    check("cap_fin", 64'(fin), 64'(N'(1) << g));
    check("cap_so", 64'(so), 64'(exp_sum[W-1:0]));
    check("cap_couto", 64'(couto), 64'(exp_sum[W]));
    check("cap_tmo", 64'(tmo), 64'(!by_fin));
    check("cap_addreq", 64'(add_req), 64'(0));
    check("hold_x", 64'(add_x), 64'(ex));
    m_ptr = PW'((int'(g) + 1) % N);
  endtask

  // Release handshake; fin must fall one edge after req[g] is seen low.
  task automatic finish_op(input logic [PW-1:0] g, input bit dropped);
    if (!dropped) begin
      cycle();
      check("done_hold", 64'({fin, so}), 64'({N'(1) << g, exp_sum[W-1:0]}));
      req[g] = 1'b0;
    end
    cycle();
    check("release", 64'({add_req, fin, tmo}), 64'(0));
    check("so_keep", 64'({couto, so}), 64'(exp_sum));
  endtask

  initial begin
    logic [PW-1:0] g;
    int            k;
    bit            drop;

    rst     = 1'b0;
    add_fin = 1'b0;
    req     = '1;
    for (int i = 0; i < N; i++) begin
      xs[i] = $urandom;
      ys[i] = $urandom;
    end
    #1 rst = 1'b1;
    cycle();
    cycle();
    check("rst_fin", 64'({fin, tmo, couto, add_req}), 64'(0));
    check("rst_so", 64'(so), 64'(0));
    check("rst_ops", 64'({add_x, add_y}), 64'(0));
    rst = 1'b0;

    // All four requesting: grants 0,1,2,3,0 with release between them.
    for (int n = 0; n < 5; n++) begin
      g = rr_pick(req, m_ptr);
      check("rr_order", 64'(g), 64'(n % N));
      case (n)
        0:       k = -1;
        1:       k = 2;
        2:       k = 5;
        3:       k = 0;
        default: k = 7;
      endcase
      run_op(g, k, 1'b0, 1'b0);
      finish_op(g, 1'b0);
      req[g] = 1'b1;
    end
    req = '0;
    cycle();

    // Single requester 2, timeout capture of 5+7.
    xs[2] = 32'd5;
    ys[2] = 32'd7;
    req   = 4'b0100;
    run_op(rr_pick(req, m_ptr), -1, 1'b0, 1'b0);
    check("sum_5_7", 64'({tmo, couto, so}), 64'({1'b1, 1'b0, 32'd12}));
    finish_op(2'd2, 1'b0);

    // Overflow with an add_fin pulse two cycles after add_req.
    xs[0] = 32'hFFFF_FFFF;
    ys[0] = 32'd1;
    req   = 4'b0001;
    run_op(rr_pick(req, m_ptr), 2, 1'b0, 1'b0);
    check("ovf", 64'({tmo, couto, so}), 64'({1'b0, 1'b1, 32'd0}));
    finish_op(2'd0, 1'b0);

    // Requester 1 drops early and changes its operands during the wait.
    req = 4'b0010;
    run_op(rr_pick(req, m_ptr), 3, 1'b1, 1'b1);
    finish_op(2'd1, 1'b1);

    // Spurious add_fin while idle must not shorten the next operation.
    add_fin = 1'b1;
    cycle();
    add_fin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("spur_idle", 64'({add_req, fin}), 64'(0));
    end
    req = 4'b1000;
    run_op(rr_pick(req, m_ptr), -1, 1'b0, 1'b0);
    finish_op(2'd3, 1'b0);

    // Reset in the middle of a wait on requester 1 (pointer would become 2).
    req = 4'b0010;
    m_ptr = rr_pick(req, m_ptr);
    cycle();
    cycle();
    cycle();
    cycle();
    check("pre_rst_req", 64'(add_req), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_out", 64'({fin, tmo, couto, add_req}), 64'(0));
    check("mid_rst_so", 64'(so), 64'(0));
    check("mid_rst_ops", 64'({add_x, add_y}), 64'(0));
    req = 4'b1010;
    cycle();
    rst   = 1'b0;
    m_ptr = '0;
    g = rr_pick(req, m_ptr);
    check("ptr_reset_pick", 64'(g), 64'(1));
    run_op(g, -1, 1'b0, 1'b0);
    finish_op(g, 1'b0);
    g = rr_pick(req, m_ptr);
    check("after_rst_pick", 64'(g), 64'(3));
    run_op(g, 1, 1'b0, 1'b0);
    finish_op(g, 1'b0);

    // Randomized operations.
    for (int n = 0; n < 30; n++) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        xs[i] = $urandom;
        ys[i] = $urandom;
      end
      k    = int'($urandom_range(0, 9)) - 1;
      drop = ($urandom_range(0, 3) == 0);
      g    = rr_pick(req, m_ptr);
      run_op(g, k, drop, $urandom_range(0, 1) == 1);
      finish_op(g, drop);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
